coeff_loader: RTL

COEFF_LOADER -- requirements
Module: coeff_loader

---
 rtl/coeff_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/coeff_loader.sv
// Coefficient loader: collects an SPI frame of NUM_COEFFS*COEFF_WIDTH bits into a shadow
// register and, only when the frame carried exactly that many bits, copies it into the
// active register that feeds the FIR datapath.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   resetN       synchronous active-low reset
//   serialIn     received SPI data bit, valid while serialEn=1
//   serialEn     one-cycle strobe per received bit
//   csN          synchronized active-low chip select, delimits a frame
//   coeffs       active coefficient set, coefficient i at [i*COEFF_WIDTH +: COEFF_WIDTH]
//   coeffUpdate  one-cycle pulse in the first cycle coeffs shows a new set
//   frameError   one-cycle pulse after a frame ended with a bad bit count
//   busy         high while a frame is being received or committed
module coeff_loader #(
  parameter int unsigned NUM_COEFFS  = 8,
  parameter int unsigned COEFF_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              serialIn,
  input  logic                              serialEn,
  input  logic                              csN,
  output logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs,
  output logic                              coeffUpdate,
  output logic                              frameError,
  output logic                              busy
);

  localparam int unsigned TOTAL_BITS = NUM_COEFFS * COEFF_WIDTH;
  localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 2);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(TOTAL_BITS);
  // One past full marks an overflowed frame; the counter parks there.
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TOTAL_BITS + 1);

  if ((COEFF_WIDTH % 8) != 0) begin : gen_width_check
    $error("COEFF_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {StIdle, StReceive, StCommit} state_t;

  state_t                  stateQ, stateD;
  logic [TOTAL_BITS-1:0]   shadowQ, shadowD;
  logic [TOTAL_BITS-1:0]   activeQ, activeD;
  logic [CNT_W-1:0]        bitCountQ, bitCountD;
  logic                    armedQ, armedD;
  logic                    coeffUpdateQ, coeffUpdateD;
  logic                    frameErrorQ, frameErrorD;
  logic [CNT_W-1:0]        countInc;
  logic [CNT_W-1:0]        finalCount;

  assign countInc = (bitCountQ == CntMax) ? bitCountQ : bitCountQ + CNT_W'(1);

  always_comb begin
    stateD       = stateQ;
    shadowD      = shadowQ;
    activeD      = activeQ;
    bitCountD    = bitCountQ;
    coeffUpdateD = 1'b0;
    frameErrorD  = 1'b0;
    finalCount   = bitCountQ;
    // After reset a frame may only start once csN has been seen high, so a frame that
    // straddles reset release is never mistaken for a fresh one.
    armedD       = armedQ | csN;

    unique case (stateQ)
      StIdle: begin
        bitCountD = '0;
        if (!csN && armedQ) begin
          stateD = StReceive;
        end
      end
      StReceive: begin
        if (serialEn) begin
          shadowD    = {shadowQ[TOTAL_BITS-2:0], serialIn};
          bitCountD  = countInc;
          finalCount = countInc;
        end
        // Frame end is judged on the count including a bit accepted this same cycle.
        if (csN) begin
          if (finalCount == CntFull) begin
            stateD = StCommit;
          end else begin
            stateD      = StIdle;
            frameErrorD = (finalCount != '0);
          end
        end
      end
      StCommit: begin
        activeD      = shadowQ;
        coeffUpdateD = 1'b1;
        stateD       = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      stateQ       <= StIdle;
      shadowQ      <= '0;
      activeQ      <= '0;
      bitCountQ    <= '0;
      armedQ       <= 1'b0;
      coeffUpdateQ <= 1'b0;
      frameErrorQ  <= 1'b0;
    end else begin
      stateQ       <= stateD;
      shadowQ      <= shadowD;
      activeQ      <= activeD;
      bitCountQ    <= bitCountD;
      armedQ       <= armedD;
      coeffUpdateQ <= coeffUpdateD;
      frameErrorQ  <= frameErrorD;
    end
  end

  assign coeffs      = activeQ;
  assign coeffUpdate = coeffUpdateQ;
  assign frameError  = frameErrorQ;
  assign busy        = (stateQ != StIdle);

endmodule
